// File: rtl/ecc_secded_dec_multi.sv
// Multi-lane SECDED (extended Hamming) decoder, 3-stage valid-qualified pipeline,
// with per-lane saturating error counters and first-failure capture.
module ecc_secded_dec_multi #(
  parameter int DATA_W  = 33,
  parameter int PAR_W   = 7,
  parameter int LANES   = 4,
  parameter int PINVERT = 1,
  parameter int CNT_W   = 16,
  localparam int CODE_W = DATA_W + PAR_W,
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      sclr,
  input  logic                      din_valid,
  input  logic [LANES*CODE_W-1:0]   din,
  input  logic                      stat_clr,
  output logic                      dout_valid,
  output logic [LANES*DATA_W-1:0]   dout,
  output logic [LANES-1:0]          dout_err,
  output logic [LANES-1:0]          dout_fail,
  output logic [LANES*CNT_W-1:0]    corr_cnt,
  output logic [LANES*CNT_W-1:0]    fail_cnt,
  output logic                      fail_seen,
  output logic [LIDX_W-1:0]         fail_lane,
  output logic [PAR_W-1:0]          fail_syn
);

  function automatic int min_par(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r + 1;
  endfunction

  if (DATA_W < 4 || PAR_W != min_par(DATA_W)) begin : g_par_check
    $error("ecc_secded_dec_multi: PAR_W inconsistent with DATA_W");
  end

  // s[0] is the overall parity; s[j+1] covers codeword positions with index bit j set
  function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      s[0] = s[0] ^ cw[i];
      for (int unsigned j = 0; j < PAR_W - 1; j++)
        if (i[j]) s[j+1] = s[j+1] ^ cw[i];
    end
    if (PINVERT != 0) s = ~s;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned n;
    d = '0;
    n = 0;
    for (int unsigned i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n < DATA_W) d[n] = cw[i];
        n++;
      end
    end
    return d;
  endfunction

  logic                 s1_valid, s2_valid;
  logic [CODE_W-1:0]    s1_code [LANES];
  logic [PAR_W-1:0]     s1_syn  [LANES];
  logic [CODE_W-1:0]    s2_code [LANES];
  logic [PAR_W-1:0]     s2_syn  [LANES];
  logic [CODE_W-1:0]    s2_mask [LANES];
  logic [LANES-1:0]     s2_err, s2_fail;

  logic [CODE_W-1:0]    mask_c [LANES];
  logic [LANES-1:0]     err_c, fail_c;
  logic [LANES*DATA_W-1:0] data_c;
  logic                 cap_hit;
  logic [LIDX_W-1:0]    cap_lane;
  logic [PAR_W-1:0]     cap_syn;

  always_comb begin
    err_c  = '0;
    fail_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      logic [PAR_W-2:0] h;
      h = s1_syn[k][PAR_W-1:1];
      mask_c[k] = '0;
      err_c[k]  = |s1_syn[k];
      if (h != '0) begin
        if (s1_syn[k][0] && (32'(h) < CODE_W)) mask_c[k][h] = 1'b1;
        else fail_c[k] = 1'b1;
      end
    end
  end

  always_comb begin
    data_c = '0;
    for (int unsigned k = 0; k < LANES; k++)
      data_c[k*DATA_W +: DATA_W] = extract(s2_code[k] ^ s2_mask[k]);
  end

  always_comb begin
    cap_hit  = 1'b0;
    cap_lane = '0;
    cap_syn  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (s2_fail[k] && !cap_hit) begin
        cap_hit  = 1'b1;
        cap_lane = LIDX_W'(k);
        cap_syn  = s2_syn[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= din_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      s1_code[k] <= din[k*CODE_W +: CODE_W];
      s1_syn[k]  <= syndrome(din[k*CODE_W +: CODE_W]);
      s2_code[k] <= s1_code[k];
      s2_syn[k]  <= s1_syn[k];
      s2_mask[k] <= mask_c[k];
    end
    s2_err  <= err_c;
    s2_fail <= fail_c;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_err   <= '0;
      dout_fail  <= '0;
    end else begin
      dout_valid <= s2_valid;
      if (s2_valid) begin
        dout      <= data_c;
        dout_err  <= s2_err;
        dout_fail <= s2_fail;
      end else begin
        dout_err  <= '0;
        dout_fail <= '0;
      end
    end
  end

  // Statistics track the word entering the output register on the same edge
  always_ff @(posedge clk) begin
    if (sclr || stat_clr) begin
      corr_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_lane <= '0;
      fail_syn  <= '0;
    end else if (s2_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (s2_err[k] && !s2_fail[k] && corr_cnt[k*CNT_W +: CNT_W] != '1)
          corr_cnt[k*CNT_W +: CNT_W] <= corr_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
        if (s2_fail[k] && fail_cnt[k*CNT_W +: CNT_W] != '1)
          fail_cnt[k*CNT_W +: CNT_W] <= fail_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (!fail_seen && cap_hit) begin
        fail_seen <= 1'b1;
        fail_lane <= cap_lane;
        fail_syn  <= cap_syn;
      end
    end
  end

endmodule
